// File: rtl/bitcell_array_ctrl.sv
// Access controller for a word-organised bitcell latch array: valid/ready request/response
// channels on the bus side, registered glitch-free sel/rw/data on the array side.
// Optional write readback check: define BITCELL_CTRL_READBACK_VERIFY_EN.
module bitcell_array_ctrl #(
    parameter int ADDR_W    = 2,
    parameter int DATA_W    = 4,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_rw,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic [2**ADDR_W-1:0] arr_sel,
    output logic                 arr_rw,
    output logic [DATA_W-1:0]    arr_in,
    input  logic [DATA_W-1:0]    arr_out
);

    localparam int WORDS = 2**ADDR_W;

    typedef enum logic [2:0] {IDLE, SETUP, WRITE, HOLD, READ, RESP} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic                wr_phase;
    logic [7:0]          cnt;

    function automatic logic [WORDS-1:0] word_select(input logic [ADDR_W-1:0] a);
        word_select    = '0;
        word_select[a] = 1'b1;
    endfunction

`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
    logic lat_rw;
    logic rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // NOTE: every register here uses <= so all array controls update together on the edge;
    // blocking assignments would let later statements see half-updated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            arr_sel   <= '0;
            arr_rw    <= 1'b0;
            arr_in    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wr_phase  <= 1'b0;
            cnt       <= '0;
`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
            lat_rw    <= 1'b0;
            rsp_err_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        wr_phase  <= req_rw;
                        arr_rw    <= req_rw;
                        arr_in    <= req_rw ? req_wdata : '0;
`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
                        lat_rw    <= req_rw;
`endif
                        state     <= SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                // rw and data have been stable for a cycle; only sel moves here
                SETUP: begin
                    cnt     <= '0;
                    arr_sel <= word_select(lat_addr);
                    if (wr_phase) begin
                        arr_rw <= 1'b1;
                        arr_in <= lat_wdata;
                        state  <= WRITE;
                    end else begin
                        arr_rw <= 1'b0;
                        arr_in <= '0;
                        state  <= READ;
                    end
                end
                WRITE: begin
                    if (cnt == 8'(WR_CYCLES - 1)) begin
                        arr_sel <= '0;
                        state   <= HOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    arr_rw <= 1'b0;
                    arr_in <= '0;
`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
                    wr_phase <= 1'b0;
                    state    <= SETUP;
`else
                    rsp_valid <= 1'b1;
                    rsp_rdata <= '0;
                    state     <= RESP;
`endif
                end
                READ: begin
                    if (cnt == 8'(RD_CYCLES - 1)) begin
                        arr_sel   <= '0;
                        rsp_rdata <= arr_out;
                        rsp_valid <= 1'b1;
`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
                        rsp_err_q <= lat_rw && (arr_out != lat_wdata);
`endif
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
                        rsp_err_q <= 1'b0;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Self-checking bench for bitcell_array_ctrl with a behavioural latch-array model;
// table-driven transactions plus hand-written backpressure, busy and reset sequences.
module tb_bitcell_array_ctrl;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int WORDS  = 4;
`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
    localparam int WR_LAT = 7;
    localparam bit RB     = 1'b1;
`else
    localparam int WR_LAT = 4;
    localparam bit RB     = 1'b0;
`endif
    localparam int RD_LAT = 3;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [WORDS-1:0]  arr_sel;
    logic              arr_rw;
    logic [DATA_W-1:0] arr_in;
    logic [DATA_W-1:0] arr_out;

    bitcell_array_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(2), .RD_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .arr_sel(arr_sel), .arr_rw(arr_rw), .arr_in(arr_in), .arr_out(arr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Level-sensitive bitcell array model with an optional stuck-at-0 mask
    logic [DATA_W-1:0] mem [WORDS];
    logic [DATA_W-1:0] stuck0;

    initial begin
        stuck0 = '0;
        for (int w = 0; w < WORDS; w++) mem[w] = '0;
    end

    always @(arr_sel or arr_rw or arr_in or stuck0) begin
        for (int w = 0; w < WORDS; w++)
            if (arr_sel[w] && arr_rw) mem[w] = arr_in & ~stuck0;
    end

    always_comb begin
        arr_out = '0;
        for (int w = 0; w < WORDS; w++)
            if (arr_sel[w] && !arr_rw) arr_out = arr_out | mem[w];
    end

    // Array-side monitor
    int               multihot;
    int               wr_cycles;
    int               hold_seen;
    logic [WORDS-1:0] wr_sel;
    logic [WORDS-1:0] prev_sel;
    logic             prev_rw;

    initial begin
        multihot = 0; wr_cycles = 0; hold_seen = 0;
        wr_sel = '0; prev_sel = '0; prev_rw = 1'b0;
    end

    always @(negedge clk) begin
        if ($countones(arr_sel) > 1) multihot = multihot + 1;
        if (arr_sel != '0 && arr_rw) begin
            wr_cycles = wr_cycles + 1;
            wr_sel    = arr_sel;
        end
        if (arr_sel == '0 && arr_rw && prev_sel != '0 && prev_rw) hold_seen = hold_seen + 1;
        prev_sel = arr_sel;
        prev_rw  = arr_rw;
    end

    int n_cmp;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", req_ready, 1);
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat);
        int lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_latency"}, lat, exp_lat);
    endtask

    task automatic do_req(input string tag, input logic rw, input logic [1:0] addr,
                          input logic [3:0] wdata, input logic [3:0] exp_rdata,
                          input logic exp_err, input int exp_lat, input int stall);
        wait_ready();
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (stall == 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check({tag, "_ready_drop"}, req_ready, 0);
        wait_rsp(tag, exp_lat);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, rsp_err, exp_err);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, rsp_valid, 1);
            check({tag, "_bp_rdata"}, rsp_rdata, exp_rdata);
            check({tag, "_bp_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid_drop"}, rsp_valid, 0);
        check({tag, "_idle_gap"}, req_ready, 0);
        @(negedge clk);
        check({tag, "_ready_back"}, req_ready, 1);
    endtask

    typedef struct {
        logic       rw;
        logic [1:0] addr;
        logic [3:0] wdata;
        logic [3:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    function automatic vec_t wr(input logic [1:0] a, input logic [3:0] d);
        vec_t v;
        v.rw = 1'b1; v.addr = a; v.wdata = d;
        v.exp_rdata = RB ? d : 4'h0; v.exp_err = 1'b0; v.exp_lat = WR_LAT;
        return v;
    endfunction

    function automatic vec_t rd(input logic [1:0] a, input logic [3:0] d);
        vec_t v;
        v.rw = 1'b0; v.addr = a; v.wdata = 4'h0;
        v.exp_rdata = d; v.exp_err = 1'b0; v.exp_lat = RD_LAT;
        return v;
    endfunction

    vec_t vecs [9];

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;

        vecs[0] = rd(2'd2, 4'hA);
        vecs[1] = wr(2'd0, 4'h1);
        vecs[2] = wr(2'd1, 4'h2);
        vecs[3] = wr(2'd2, 4'h4);
        vecs[4] = wr(2'd3, 4'h8);
        vecs[5] = rd(2'd0, 4'h1);
        vecs[6] = rd(2'd1, 4'h2);
        vecs[7] = rd(2'd2, 4'h4);
        vecs[8] = rd(2'd3, 4'h8);

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_arr_sel", arr_sel, 0);
        check("rst_arr_rw", arr_rw, 0);
        check("rst_arr_in", arr_in, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("rel_ready_low", req_ready, 0);
        @(negedge clk);
        check("rel_ready_high", req_ready, 1);

        // First write: sel pulse width and sel-before-rw release ordering
        wr_cycles = 0; hold_seen = 0; wr_sel = '0;
        do_req("w_a2", 1'b1, 2'd2, 4'hA, RB ? 4'hA : 4'h0, 1'b0, WR_LAT, 0);
        check("w_a2_pulse_cycles", wr_cycles, 2);
        check("w_a2_pulse_sel", wr_sel, 4'b0100);
        check("w_a2_hold_seen", hold_seen, 1);

        for (int i = 0; i < 9; i++)
            do_req($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_lat, 0);

        // Response backpressure for 5 cycles
        do_req("bp_rd_a2", 1'b0, 2'd2, 4'h0, 4'h4, 1'b0, RD_LAT, 5);

        // Source holds req_valid with a new address while the controller is busy
        wait_ready();
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_rw = 1'b0; req_addr = 2'd1;
        @(posedge clk);
        #1 req_addr = 2'd3;
        wait_rsp("busy_first", RD_LAT);
        check("busy_first_rdata", rsp_rdata, 4'h2);
        check("busy_first_ready", req_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("busy_gap_ready", req_ready, 0);
        @(negedge clk);
        check("busy_second_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("busy_second_accept", req_ready, 0);
        wait_rsp("busy_second", RD_LAT);
        check("busy_second_rdata", rsp_rdata, 4'h8);
        @(posedge clk);
        @(negedge clk);
        check("busy_second_done", rsp_valid, 0);

        // Asynchronous reset in the middle of a write to word 0
        wait_ready();
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 2'd0; req_wdata = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("mid_sel_active", arr_sel, 4'b0001);
        check("mid_rw_active", arr_rw, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", arr_sel, 0);
        check("mid_rst_rw", arr_rw, 0);
        check("mid_rst_in", arr_in, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rel_ready_low", req_ready, 0);
        @(negedge clk);
        check("mid_rel_ready_high", req_ready, 1);
        do_req("post_rd_a1", 1'b0, 2'd1, 4'h0, 4'h2, 1'b0, RD_LAT, 0);
        do_req("post_rd_a2", 1'b0, 2'd2, 4'h0, 4'h4, 1'b0, RD_LAT, 0);
        do_req("post_rd_a3", 1'b0, 2'd3, 4'h0, 4'h8, 1'b0, RD_LAT, 0);
        do_req("post_wr_a0", 1'b1, 2'd0, 4'h3, RB ? 4'h3 : 4'h0, 1'b0, WR_LAT, 0);
        do_req("post_rd_a0", 1'b0, 2'd0, 4'h0, 4'h3, 1'b0, RD_LAT, 0);

`ifdef BITCELL_CTRL_READBACK_VERIFY_EN
        do_req("rb_good", 1'b1, 2'd2, 4'h5, 4'h5, 1'b0, 7, 0);
        stuck0 = 4'b0001;
        do_req("rb_stuck", 1'b1, 2'd3, 4'h5, 4'h4, 1'b1, 7, 0);
        stuck0 = 4'b0000;
`endif

        check("never_multi_hot", multihot, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
